// File: rtl/store_buffer.sv
// Posted-store FIFO between MEM stage and data memory. Loads own the single memory port;
// buffered stores drain one per idle cycle, and loads to a pending word stall until it drains.
module store_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [2:0]               st_funct3,
  input  logic [ADDR_WIDTH-1:0]    st_addr,
  input  logic [DATA_WIDTH-1:0]    st_data,
  output logic                     st_ready,
  output logic                     st_err,
  input  logic                     ld_valid,
  input  logic [2:0]               ld_funct3,
  input  logic [ADDR_WIDTH-1:0]    ld_addr,
  output logic                     ld_stall,
  input  logic                     fence_req,
  output logic                     fence_busy,
  output logic                     mem_wr_en,
  output logic [2:0]               mem_funct3,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wr_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = PW - 1;
  localparam logic [PW-1:0] PtrOne = 1;

  logic [2:0]            f3_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic                  st_err_q;

  logic [IW-1:0] wr_idx, rd_idx;
  logic          full, legal, push, pop, load_go, hit;

  assign wr_idx = wr_ptr_q[IW-1:0];
  assign rd_idx = rd_ptr_q[IW-1:0];

  // Full when the pointers differ only in the wrap bit.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_idx == rd_idx);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign st_ready = !full;
  assign st_err   = st_err_q;

  assign legal = (st_funct3 == 3'b000) || (st_funct3 == 3'b001) || (st_funct3 == 3'b010);
  assign push  = st_valid && st_ready && legal;

  // A same-cycle accepted store counts as older than the load.
  always_comb begin
    hit = push && (st_addr[ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2])) begin
        hit = 1'b1;
      end
    end
  end

  assign ld_stall   = ld_valid && hit;
  assign load_go    = ld_valid && !ld_stall;
  assign pop        = !load_go && !empty;
  assign fence_busy = fence_req && !empty;

  always_comb begin
    mem_wr_en   = 1'b0;
    mem_funct3  = 3'b000;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (load_go) begin
      mem_funct3 = ld_funct3;
      mem_addr   = ld_addr;
    end else if (!empty) begin
      mem_wr_en   = 1'b1;
      mem_funct3  = f3_q[rd_idx];
      mem_addr    = addr_q[rd_idx];
      mem_wr_data = data_q[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
      st_err_q <= 1'b0;
    end else begin
      st_err_q <= st_valid && !legal;
      if (push) begin
        valid_q[wr_idx] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        valid_q[rd_idx] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PtrOne;
      end
    end
  end

  // Payload needs no reset; the valid bits and pointers qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      f3_q[wr_idx]   <= st_funct3;
      addr_q[wr_idx] <= st_addr;
      data_q[wr_idx] <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed and randomized checks of store_buffer against a queue-based reference model.
module tb_store_buffer;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic st_valid, ld_valid, fence_req;
  logic [2:0] st_funct3, ld_funct3;
  logic [AW-1:0] st_addr, ld_addr;
  logic [DW-1:0] st_data;
  logic st_ready, st_err, ld_stall, fence_busy, mem_wr_en, empty;
  logic [2:0] mem_funct3;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [$clog2(DEPTH):0] count;

  store_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .st_err(st_err),
    .ld_valid(ld_valid), .ld_funct3(ld_funct3), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .fence_req(fence_req), .fence_busy(fence_busy),
    .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  // Byte-addressed data memory written by the DUT's write port.
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr[7:0]] <= mem_wr_data[7:0];
      if (mem_funct3 != 3'b000) mem[mem_addr[7:0] + 8'd1] <= mem_wr_data[15:8];
      if (mem_funct3 == 3'b010) begin
        mem[mem_addr[7:0] + 8'd2] <= mem_wr_data[23:16];
        mem[mem_addr[7:0] + 8'd3] <= mem_wr_data[31:24];
      end
    end
  end

  typedef struct {
    logic [2:0]    f3;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  logic err_q;
  logic nxt_push, nxt_pop, nxt_err;
  ent_t nxt_ent;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    st_valid = 1'b0; st_funct3 = 3'b010; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_funct3 = 3'b010; ld_addr = '0; fence_req = 1'b0;
  endtask

  task automatic store(input logic [2:0] f3, input logic [AW-1:0] a, input logic [DW-1:0] d);
    st_valid = 1'b1; st_funct3 = f3; st_addr = a; st_data = d;
  endtask

  task automatic load(input logic [2:0] f3, input logic [AW-1:0] a);
    ld_valid = 1'b1; ld_funct3 = f3; ld_addr = a;
  endtask

  // Let inputs settle and compare every output with the model.
  task automatic settle();
    int n;
    logic match, go;
    #1;
    n = q.size();
    nxt_push = st_valid && (st_funct3 <= 3'b010) && (n < DEPTH);
    nxt_err  = st_valid && (st_funct3 > 3'b010);
    nxt_ent  = '{f3: st_funct3, a: st_addr, d: st_data};
    match = nxt_push && (st_addr[AW-1:2] == ld_addr[AW-1:2]);
    foreach (q[i]) if (q[i].a[AW-1:2] == ld_addr[AW-1:2]) match = 1'b1;
    go = ld_valid && !match;
    nxt_pop = !go && (n > 0);
    chk("st_ready", st_ready, n < DEPTH);
    chk("st_err", st_err, err_q);
    chk("ld_stall", ld_stall, ld_valid && match);
    chk("fence_busy", fence_busy, fence_req && (n > 0));
    chk("empty", empty, n == 0);
    chk("count", count, n);
    chk("mem_wr_en", mem_wr_en, nxt_pop);
    if (go) begin
      chk("mem_funct3", mem_funct3, ld_funct3);
      chk("mem_addr", mem_addr, ld_addr);
      chk("mem_wr_data", mem_wr_data, 0);
    end else if (n > 0) begin
      chk("mem_funct3", mem_funct3, q[0].f3);
      chk("mem_addr", mem_addr, q[0].a);
      chk("mem_wr_data", mem_wr_data, q[0].d);
    end else begin
      chk("mem_funct3", mem_funct3, 0);
      chk("mem_addr", mem_addr, 0);
      chk("mem_wr_data", mem_wr_data, 0);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (nxt_pop) void'(q.pop_front());
    if (nxt_push) q.push_back(nxt_ent);
    err_q = nxt_err;
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    q.delete();
    err_q = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", st_ready, 1);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_err", st_err, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    idle();
    err_q = 1'b0;
    #2;
    do_reset();

    // Single word store drains on the next cycle.
    store(3'b010, 32'h10, 32'hDEADBEEF);
    step();
    idle();
    settle();
    chk("t1_wr_en", mem_wr_en, 1);
    chk("t1_addr", mem_addr, 32'h10);
    chk("t1_f3", mem_funct3, 3'b010);
    advance();
    settle();
    chk("t1_empty", empty, 1);
    advance();

    // Fill while a non-matching load owns the port.
    load(3'b010, 32'h80);
    for (int k = 0; k < 4; k++) begin
      store(3'b010, 32'h10 + 32'(4 * k), 32'h1000 + 32'(k));
      step();
    end
    store(3'b010, 32'h30, 32'h5555);
    settle();
    chk("t2_count", count, 4);
    chk("t2_ready", st_ready, 0);
    advance();
    settle();
    chk("t2_count_hold", count, 4);
    idle();
    for (int k = 0; k < 4; k++) step();
    settle();
    chk("t2_drained", empty, 1);
    advance();

    // Byte store pending, load to the same word stalls until it drains.
    store(3'b000, 32'h21, 32'h123456AB);
    step();
    idle();
    load(3'b100, 32'h20);
    settle();
    chk("t3_stall", ld_stall, 1);
    chk("t3_drain", mem_wr_en, 1);
    advance();
    settle();
    chk("t3_go", ld_stall, 0);
    chk("t3_addr", mem_addr, 32'h20);
    chk("t3_rd", mem_wr_en, 0);
    chk("t3_byte", mem[8'h21], 8'hAB);
    chk("t3_lbu", mem[8'h20], 8'h00);
    advance();
    idle();

    // Same-cycle store and load to one word.
    store(3'b010, 32'h40, 32'hCAFEF00D);
    load(3'b010, 32'h40);
    settle();
    chk("t4_stall0", ld_stall, 1);
    advance();
    st_valid = 1'b0;
    settle();
    chk("t4_stall1", ld_stall, 1);
    chk("t4_wr", mem_wr_en, 1);
    advance();
    settle();
    chk("t4_go", ld_stall, 0);
    chk("t4_rd", mem_wr_en, 0);
    advance();
    idle();

    // Illegal store size.
    store(3'b011, 32'h50, 32'h77);
    step();
    idle();
    settle();
    chk("t5_err", st_err, 1);
    chk("t5_count", count, 0);
    advance();
    settle();
    chk("t5_err_clr", st_err, 0);
    advance();

    // Fence over three pending stores, then the same with a reset mid-drain.
    for (int rep = 0; rep < 2; rep++) begin
      load(3'b010, 32'h80);
      for (int k = 0; k < 3; k++) begin
        store(3'b010, 32'h60 + 32'(4 * k), 32'(k));
        step();
      end
      idle();
      fence_req = 1'b1;
      if (rep == 0) begin
        for (int k = 0; k < 3; k++) begin
          settle();
          chk("t6_busy", fence_busy, 1);
          advance();
        end
        settle();
        chk("t6_done", fence_busy, 0);
        advance();
      end else begin
        step();
        do_reset();
        settle();
        chk("t6_rst_busy", fence_busy, 0);
        advance();
      end
      idle();
    end

    // Randomized traffic over a small address window so hazards are common.
    for (int c = 0; c < 600; c++) begin
      st_valid  = ($urandom_range(0, 99) < 55);
      st_funct3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      st_addr   = 32'($urandom_range(0, 63));
      st_data   = $urandom;
      ld_valid  = ($urandom_range(0, 99) < 40);
      ld_funct3 = 3'($urandom_range(0, 5));
      ld_addr   = 32'($urandom_range(0, 127));
      fence_req = ($urandom_range(0, 3) == 0);
      step();
    end
    idle();
    for (int k = 0; k < DEPTH + 1; k++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
